// File: rtl/e6809_bus_master_pkg.sv
// Shared definitions for the 6809-style bus master: the four bus-clock
// phases and the default dead-cycle address.
package e6809_bus_master_pkg;

    typedef enum logic [1:0] {
        P0 = 2'd0,   // Q=0 E=0
        P1 = 2'd1,   // Q=1 E=0
        P2 = 2'd2,   // Q=1 E=1
        P3 = 2'd3    // Q=0 E=1, stretchable by MRDY
    } phase_t;

    localparam logic [15:0] IDLE_ADDR_DEFAULT = 16'hFFFF;
    localparam int          STRETCH_W         = 4;

endpackage

// File: rtl/e6809_bus_master_if.sv
// Request/response handshake plus the external 6809 bus pins, bundled so the
// master and its client/bus model can be wired with one connection.
interface e6809_bus_master_if;

    logic        REQ_VALID;
    logic        REQ_READY;
    logic        REQ_RNW;
    logic [15:0] REQ_ADDR;
    logic [7:0]  REQ_WDATA;
    logic        REQ_VECTOR;

    logic        RSP_VALID;
    logic [7:0]  RSP_RDATA;
    logic        RSP_TIMEOUT;

    logic        Q;
    logic        E;
    logic [15:0] ADDR;
    logic        RnW;
    logic        BA;
    logic        BS;
    logic [7:0]  DATA_OUT;
    logic        DATA_OE;
    logic [7:0]  DATA_IN;
    logic        MRDY;

    modport master (
        input  REQ_VALID, REQ_RNW, REQ_ADDR, REQ_WDATA, REQ_VECTOR,
        output REQ_READY,
        output RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        output Q, E, ADDR, RnW, BA, BS, DATA_OUT, DATA_OE,
        input  DATA_IN, MRDY
    );

    modport slave (
        output REQ_VALID, REQ_RNW, REQ_ADDR, REQ_WDATA, REQ_VECTOR,
        input  REQ_READY,
        input  RSP_VALID, RSP_RDATA, RSP_TIMEOUT,
        input  Q, E, ADDR, RnW, BA, BS, DATA_OUT, DATA_OE,
        output DATA_IN, MRDY
    );

endinterface

// File: rtl/e6809_bus_master_eq_clock_gen.sv
// Quadrature Q/E generator: free-running four-phase sequence with the E-high
// P3 phase stretched by MRDY, bounded by a saturating stretch counter.
module eq_clock_gen
    import e6809_bus_master_pkg::*;
#(
    parameter int MRDY_TIMEOUT = 15
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   mrdy,
    output phase_t phase,
    output logic   q,
    output logic   e,
    output logic   cycle_end,
    output logic   timeout
);

    // Count value seen on the last permitted P3 clock.
    localparam logic [STRETCH_W-1:0] CNT_LAST = STRETCH_W'(MRDY_TIMEOUT - 1);

    phase_t               phase_q;
    phase_t               phase_d;
    logic [STRETCH_W-1:0] stretch_cnt;

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) phase_q <= P0;
        else     phase_q <= phase_d;
    end

    // Next phase and end-of-cycle strobe; P3 ends on MRDY or when the stretch limit is hit.
    always_comb begin
        phase_d   = phase_q;
        cycle_end = 1'b0;
        timeout   = 1'b0;
        case (phase_q)
            P0: phase_d = P1;
            P1: phase_d = P2;
            P2: phase_d = P3;
            P3: begin
                if (mrdy || (stretch_cnt == CNT_LAST)) begin
                    cycle_end = 1'b1;
                    timeout   = ~mrdy;
                    phase_d   = P0;
                end
            end
            default: phase_d = P0;
        endcase
    end

    // Stretch counter: cleared entering P3, counts held P3 clocks, saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stretch_cnt <= '0;
        end else if (phase_q == P2) begin
            stretch_cnt <= '0;
        end else if ((phase_q == P3) && !cycle_end && (stretch_cnt != '1)) begin
            stretch_cnt <= stretch_cnt + 1'b1;
        end
    end

    assign phase = phase_q;
    assign q     = (phase_q == P1) || (phase_q == P2);
    assign e     = (phase_q == P2) || (phase_q == P3);

endmodule

// File: rtl/e6809_bus_master.sv
// 6809-style bus master: turns a valid/ready request stream into Q/E bus
// cycles, runs dead cycles when idle, and returns a one-clock response.
module e6809_bus_master
    import e6809_bus_master_pkg::*;
#(
    parameter logic [15:0] IDLE_ADDR    = IDLE_ADDR_DEFAULT,
    parameter int          MRDY_TIMEOUT = 15
) (
    input logic               CLKX4,
    input logic               RESET,
    e6809_bus_master_if.master bus
);

    phase_t      phase;
    logic        cycle_end;
    logic        timeout;

    logic        active;
    logic        rnw_q;
    logic [15:0] addr_q;
    logic        vector_q;
    logic [7:0]  wdata_q;

    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_timeout_q;

    eq_clock_gen #(
        .MRDY_TIMEOUT(MRDY_TIMEOUT)
    ) u_clk_gen (
        .clk       (CLKX4),
        .rst       (RESET),
        .mrdy      (bus.MRDY),
        .phase     (phase),
        .q         (bus.Q),
        .e         (bus.E),
        .cycle_end (cycle_end),
        .timeout   (timeout)
    );

    // Latch the next cycle's qualifiers at the end of P3; no request means a dead cycle.
    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            active   <= 1'b0;
            addr_q   <= IDLE_ADDR;
            rnw_q    <= 1'b1;
            vector_q <= 1'b0;
            wdata_q  <= 8'h00;
        end else if (cycle_end) begin
            if (bus.REQ_VALID) begin
                active   <= 1'b1;
                addr_q   <= bus.REQ_ADDR;
                rnw_q    <= bus.REQ_RNW;
                vector_q <= bus.REQ_VECTOR;
                wdata_q  <= bus.REQ_WDATA;
            end else begin
                active   <= 1'b0;
                addr_q   <= IDLE_ADDR;
                rnw_q    <= 1'b1;
                vector_q <= 1'b0;
            end
        end
    end

    // Completion pulse in the P0 after a real cycle; read data captured as E falls.
    always_ff @(posedge CLKX4) begin
        if (RESET) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q   <= cycle_end & active;
            rsp_timeout_q <= cycle_end & active & timeout;
            if (cycle_end && active && rnw_q) begin
                rsp_rdata_q <= timeout ? 8'hFF : bus.DATA_IN;
            end
        end
    end

    assign bus.REQ_READY   = cycle_end & ~RESET;
    assign bus.ADDR        = addr_q;
    assign bus.RnW         = rnw_q;
    assign bus.BA          = 1'b0;
    assign bus.BS          = vector_q;
    assign bus.DATA_OUT    = wdata_q;
    assign bus.DATA_OE     = active & ~rnw_q & (phase != P0) & ~RESET;
    assign bus.RSP_VALID   = rsp_valid_q;
    assign bus.RSP_RDATA   = rsp_rdata_q;
    assign bus.RSP_TIMEOUT = rsp_timeout_q;

endmodule

// File: tb/tb_e6809_bus_master.sv
// Bench for e6809_bus_master: cycle-by-cycle bus model plus response scoreboard.
module tb_e6809_bus_master;
    import e6809_bus_master_pkg::*;

    typedef struct {
        bit          rnw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          vec;
        int          stall;
        logic [7:0]  din;
        int          gap;
        bit          rst_p2;
    } req_t;

    typedef struct {
        logic [7:0] rdata;
        bit         to;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    e6809_bus_master_if bif();

    e6809_bus_master #(
        .IDLE_ADDR   (16'hFFFF),
        .MRDY_TIMEOUT(15)
    ) dut (
        .CLKX4 (clk),
        .RESET (rst),
        .bus   (bif.master)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    rsp_t sbq[$];
    req_t stim[$];

    int         sidx, gapcnt, p3cnt, exp_ph, done_cnt, cyc, ehigh, exp_ehigh;
    bit         cur_active, chk_ehigh, end_exp, to_flag;
    req_t       cur;
    logic [7:0] last_rdata;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] qe_of(input int p);
        case (p)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic add_req(input bit rnw, input logic [15:0] addr, input logic [7:0] wdata,
                           input bit vec, input int stall, input logic [7:0] din,
                           input int gap, input bit rst_p2);
        req_t r;
        r.rnw = rnw; r.addr = addr; r.wdata = wdata; r.vec = vec;
        r.stall = stall; r.din = din; r.gap = gap; r.rst_p2 = rst_p2;
        stim.push_back(r);
    endtask

    task automatic check_reset_vals();
        check_eq("rst_qe",      32'({bif.Q, bif.E}), 32'd0);
        check_eq("rst_addr",    32'(bif.ADDR),       32'hFFFF);
        check_eq("rst_rnw",     32'(bif.RnW),        32'd1);
        check_eq("rst_ba_bs",   32'({bif.BA, bif.BS}), 32'd0);
        check_eq("rst_oe",      32'(bif.DATA_OE),    32'd0);
        check_eq("rst_dout",    32'(bif.DATA_OUT),   32'd0);
        check_eq("rst_ready",   32'(bif.REQ_READY),  32'd0);
        check_eq("rst_rvalid",  32'(bif.RSP_VALID),  32'd0);
        check_eq("rst_rdata",   32'(bif.RSP_RDATA),  32'd0);
        check_eq("rst_timeout", 32'(bif.RSP_TIMEOUT), 32'd0);
    endtask

    // Called at each P0: drop the previous request, maybe present the next one.
    task automatic p0_load();
        bif.REQ_VALID = 1'b0;
        bif.MRDY      = 1'b1;
        bif.DATA_IN   = 8'hAA;
        if (sidx < stim.size()) begin
            if (gapcnt > 0) begin
                gapcnt--;
            end else begin
                bif.REQ_VALID  = 1'b1;
                bif.REQ_RNW    = stim[sidx].rnw;
                bif.REQ_ADDR   = stim[sidx].addr;
                bif.REQ_WDATA  = stim[sidx].wdata;
                bif.REQ_VECTOR = stim[sidx].vec;
            end
        end
    endtask

    task automatic check_quals();
        check_eq("addr",  32'(bif.ADDR), cur_active ? 32'(cur.addr) : 32'hFFFF);
        check_eq("rnw",   32'(bif.RnW),  cur_active ? 32'(cur.rnw)  : 32'd1);
        check_eq("ba",    32'(bif.BA),   32'd0);
        check_eq("bs",    32'(bif.BS),   cur_active ? 32'(cur.vec)  : 32'd0);
        if (cur_active && !cur.rnw) check_eq("dout", 32'(bif.DATA_OUT), 32'(cur.wdata));
    endtask

    task automatic do_mid_reset();
        rst = 1'b1;
        @(negedge clk); cyc++;
        check_reset_vals();
        @(negedge clk); cyc++;
        check_reset_vals();
        rst        = 1'b0;
        last_rdata = 8'h00;
        cur_active = 1'b0;
        p3cnt      = 0;
        ehigh      = 0;
        chk_ehigh  = 1'b0;
        p0_load();
        exp_ph     = 1;
    endtask

    // Response scoreboard: each RSP_VALID pulse must match the oldest expected completion.
    always @(negedge clk) begin
        rsp_t r;
        if (bif.RSP_VALID === 1'b1) begin
            if (sbq.size() == 0) begin
                check_eq("rsp_unexpected", 32'(bif.RSP_VALID), 32'd0);
            end else begin
                r = sbq.pop_front();
                check_eq("rsp_rdata",   32'(bif.RSP_RDATA),   32'(r.rdata));
                check_eq("rsp_timeout", 32'(bif.RSP_TIMEOUT), 32'(r.to));
            end
        end else begin
            check_eq("rsp_timeout_idle", 32'(bif.RSP_TIMEOUT), 32'd0);
        end
    end

    initial begin
        //        rnw  addr      wdata  vec stall din    gap rst_p2
        add_req(1'b1, 16'hFE10, 8'h00, 1'b0, 0,  8'h03, 0, 1'b0);
        add_req(1'b0, 16'hFE12, 8'h15, 1'b0, 0,  8'h00, 1, 1'b0);
        add_req(1'b1, 16'h1234, 8'h00, 1'b0, 3,  8'h5A, 0, 1'b0);
        add_req(1'b1, 16'h2000, 8'h00, 1'b0, 99, 8'h77, 0, 1'b0);
        add_req(1'b1, 16'h3000, 8'h00, 1'b0, 0,  8'hC3, 0, 1'b0);
        add_req(1'b0, 16'h4000, 8'hA5, 1'b0, 2,  8'h00, 0, 1'b0);
        add_req(1'b1, 16'hFFFE, 8'h00, 1'b1, 0,  8'h12, 1, 1'b0);
        add_req(1'b1, 16'hFFFF, 8'h00, 1'b1, 0,  8'h34, 0, 1'b0);
        add_req(1'b0, 16'h5555, 8'h66, 1'b0, 0,  8'h00, 0, 1'b1);
        add_req(1'b1, 16'h0001, 8'h00, 1'b0, 0,  8'h9C, 0, 1'b0);

        bif.REQ_VALID = 1'b0; bif.REQ_RNW = 1'b1; bif.REQ_ADDR = 16'h0000;
        bif.REQ_WDATA = 8'h00; bif.REQ_VECTOR = 1'b0;
        bif.MRDY = 1'b1; bif.DATA_IN = 8'hAA;
        sidx = 0; gapcnt = stim[0].gap; p3cnt = 0; done_cnt = 0; cyc = 0;
        ehigh = 0; exp_ehigh = 0; chk_ehigh = 1'b0; cur_active = 1'b0;
        last_rdata = 8'h00;
        cur = stim[0];

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        p0_load();
        exp_ph = 1;

        while (cyc < 2000 && !(sidx == stim.size() && done_cnt >= 2)) begin
            @(negedge clk); cyc++;
            if (bif.E === 1'b1) ehigh++;
            check_eq("phase_qe", 32'({bif.Q, bif.E}), 32'(qe_of(exp_ph)));
            check_quals();
            case (exp_ph)
                0: begin
                    check_eq("oe_p0",    32'(bif.DATA_OE),   32'd0);
                    check_eq("ready_p0", 32'(bif.REQ_READY), 32'd0);
                    if (chk_ehigh) check_eq("e_high_clocks", 32'(ehigh), 32'(exp_ehigh));
                    ehigh = 0;
                    p0_load();
                    exp_ph = 1;
                end
                1, 2: begin
                    check_eq("oe_p12",    32'(bif.DATA_OE),   32'(cur_active && !cur.rnw));
                    check_eq("ready_p12", 32'(bif.REQ_READY), 32'd0);
                    if (exp_ph == 2 && cur_active && cur.rst_p2) do_mid_reset();
                    else exp_ph++;
                end
                default: begin
                    bif.MRDY    = (p3cnt >= (cur_active ? cur.stall : 0));
                    bif.DATA_IN = cur_active ? cur.din : 8'h5A;
                    #1;
                    end_exp = bif.MRDY || (p3cnt + 1 >= 15);
                    check_eq("ready_p3", 32'(bif.REQ_READY), 32'(end_exp));
                    check_eq("oe_p3",    32'(bif.DATA_OE),   32'(cur_active && !cur.rnw));
                    p3cnt++;
                    if (end_exp) begin
                        chk_ehigh = cur_active;
                        if (cur_active) begin
                            to_flag = !bif.MRDY;
                            if (cur.rnw) last_rdata = to_flag ? 8'hFF : cur.din;
                            sbq.push_back('{last_rdata, to_flag});
                            exp_ehigh = 1 + ((cur.stall >= 15) ? 15 : cur.stall + 1);
                        end
                        if (bif.REQ_VALID) begin
                            cur        = stim[sidx];
                            cur_active = 1'b1;
                            sidx++;
                            if (sidx < stim.size()) gapcnt = stim[sidx].gap;
                        end else begin
                            cur_active = 1'b0;
                        end
                        if (sidx == stim.size()) done_cnt++;
                        p3cnt  = 0;
                        exp_ph = 0;
                    end
                end
            endcase
        end
        if (cyc >= 2000) check_eq("cycle_budget", 32'(cyc), 32'd0);

        bif.MRDY = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("sb_drain", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e6809_bus_master.md
E6809_BUS_MASTER -- requirements
Module: e6809_bus_master

Interface
REQ-001 Parameter IDLE_ADDR, 16'hFFFF, address driven during dead (no-request) bus cycles.
REQ-002 Parameter MRDY_TIMEOUT, 15, maximum consecutive CLKX4 cycles of MRDY-stretch before a forced cycle end (range 1..15).
REQ-003 The block SHALL have one clock, CLKX4, and a synchronous, active-high reset, RESET.
REQ-004 CLKX4  in  1  master clock, four clocks per unstretched bus cycle.
REQ-005 RESET  in  1  synchronous active-high reset.
REQ-006 REQ_VALID  in  1  request pending.
REQ-007 REQ_READY  out  1  request accepted on this edge if REQ_VALID.
REQ-008 REQ_RNW  in  1  1=read, 0=write.
REQ-009 REQ_ADDR  in  16  target address.
REQ-010 REQ_WDATA  in  8  write data.
REQ-011 REQ_VECTOR  in  1  vector fetch (drive BA=0, BS=1).
REQ-012 RSP_VALID  out  1  one-clock completion pulse.
REQ-013 RSP_RDATA  out  8  read data.
REQ-014 RSP_TIMEOUT  out  1  qualifies RSP_VALID: cycle ended by timeout.
REQ-015 Q, E  out  1 each  quadrature bus clocks.
REQ-016 ADDR  out  16;  RnW  out  1;  BA  out  1;  BS  out  1  bus cycle qualifiers.
REQ-017 DATA_OUT  out  8;  DATA_OE  out  1;  DATA_IN  in  8  split data bus (pad tristate outside block).
REQ-018 MRDY  in  1  0 = stretch E-high phase.

Function
REQ-019 Phases SHALL run continuously: P0 {Q,E}=00, P1=10, P2=11, P3=01, then P0; each lasts one CLKX4 except P3.
REQ-020 P3 SHALL repeat while MRDY=0 and stretch count < MRDY_TIMEOUT; it ends on the first P3 clock with MRDY=1, or when the count reaches MRDY_TIMEOUT.
REQ-021 REQ_READY SHALL be 1 exactly on the final clock of P3 (cycle about to end), else 0.
REQ-022 On an accepting edge, REQ_* are registered; ADDR, RnW, BA=0, BS=REQ_VECTOR are driven from the following P0 through that cycle's P3.
REQ-023 With no accepted request, the next cycle SHALL be a dead cycle: ADDR=IDLE_ADDR, RnW=1, BA=0, BS=0, DATA_OE=0, no response.
REQ-024 Write cycles: DATA_OUT=REQ_WDATA held P0..P3; DATA_OE=1 in P1, P2, P3 only.
REQ-025 Read cycles: DATA_IN SHALL be sampled on the edge leaving P3 (E falling) into RSP_RDATA.
REQ-026 RSP_VALID SHALL pulse for one clock, in the P0 following any non-dead cycle (read or write); writes leave RSP_RDATA unchanged.
REQ-027 Timeout end: RSP_TIMEOUT=1 with that pulse; reads return RSP_RDATA=8'hFF; RSP_TIMEOUT=0 at all other times.
REQ-028 Back-to-back requests SHALL produce back-to-back bus cycles with no dead cycle between.
REQ-029 Stretch counter SHALL clear on entry to P3 and never wrap.

Reset
REQ-030 While RESET=1: phase=P0, Q=E=0, ADDR=IDLE_ADDR, RnW=1, BA=BS=0, DATA_OE=0, DATA_OUT=0, REQ_READY=0, RSP_VALID=0, RSP_RDATA=0, RSP_TIMEOUT=0.
REQ-031 Reset mid-cycle SHALL abandon the cycle with no response; the first cycle after release is a dead cycle, REQ_READY first asserting in its P3 (clock 4 after release).

Structure
REQ-032 Shared package holds the phase typedef (P0..P3) and the IDLE_ADDR default constant.
REQ-033 One sub-module, eq_clock_gen: phase state, Q/E outputs, MRDY stretch counter, end-of-cycle strobe.

Verification
REQ-034 Read FE10, DATA_IN=8'h03 in P3 -> ADDR=FE10, RnW=1 for P0..P3; RSP_VALID one clock, RSP_RDATA=8'h03, RSP_TIMEOUT=0.
REQ-035 Write FE12 data 8'h15 -> RnW=0, DATA_OE=1 exactly P1..P3, DATA_OUT=8'h15; RSP_VALID pulse.
REQ-036 Read with MRDY=0 for 3 P3 clocks -> P3 lasts 4 clocks, E high 5 clocks total, data sampled on E fall.
REQ-037 MRDY held 0 -> P3 lasts 15 clocks, RSP_TIMEOUT=1, RSP_RDATA=8'hFF, next cycle normal.
REQ-038 Vector read FFFE then FFFF back-to-back -> BA=0, BS=1 both cycles, no dead cycle between, two RSP_VALID pulses 4 clocks apart.
REQ-039 RESET asserted in P2 of a write -> DATA_OE=0 next clock, no RSP_VALID, dead cycle after release with ADDR=FFFF.
